fmcw_frame_ctrl: RTL and testbench

Parametrised capture and readout controller between the decimating FIR output and the FFT/USB path. It replaces the fixed single-channel counter-plus-RAM with a ramp-synchronised, multi-channel, ping-pong frame buffer. Captures FRAME_LEN samples per channel after each chirp start, skipping a programmable settling window. Streams each committed frame as a tagged word stream: header, then channel-interleaved samples, under a valid/ready handshake. Single clock domain (clk_i); ramp_start_i is already synchronous to clk_i.

---
 rtl/fmcw_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_fmcw_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmcw_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fmcw_frame_ctrl
// Purpose  : Ramp-synchronised multi-channel capture into a ping-pong frame
//            buffer, with tagged stream readout (header + interleaved samples)
//            under a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fmcw_frame_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int N_CHAN     = 2,
    parameter int FRAME_LEN  = 1024,
    parameter int OUT_WIDTH  = 16,
    parameter int SKIP_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         sample_en_i,
    input  logic [N_CHAN*DATA_WIDTH-1:0] din_i,
    input  logic                         ramp_start_i,
    input  logic                         arm_i,
    input  logic                         single_i,
    input  logic [SKIP_WIDTH-1:0]        skip_i,
    output logic [OUT_WIDTH-1:0]         out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic [7:0]                   drop_count_o
);

    localparam int AW    = $clog2(FRAME_LEN);
    localparam int ROW_W = N_CHAN * DATA_WIDTH;
    localparam int CW    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int SEQ_W = OUT_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RAMP = 2'd1,
        SKIP      = 2'd2,
        CAPTURE   = 2'd3
    } cap_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_HEADER = 2'd1,
        R_DATA   = 2'd2
    } rd_state_t;

    // Capture side state
    cap_state_t            cap_state_q, cap_state_d;
    logic                  arm_prev_q, arm_prev_d;
    logic                  ramp_prev_q, ramp_prev_d;
    logic                  single_q, single_d;
    logic [SKIP_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [SEQ_W-1:0]      hdr_seq_q, hdr_seq_d;
    logic [7:0]            drop_q, drop_d;
    logic                  rd_full_q, rd_full_d;

    // Readout side state
    rd_state_t             r_state_q, r_state_d;
    logic [AW-1:0]         row_q, row_d;
    logic [CW-1:0]         chan_q, chan_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;

    // Frame memory: bank select in the MSB of the address
    logic [ROW_W-1:0]      mem [0:2*FRAME_LEN-1];
    logic [ROW_W-1:0]      rd_row_q;
    logic                  mem_we;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;

    logic                  arm_rise;
    logic                  ramp_rise;
    logic                  commit;
    logic                  last_xfer;
    logic                  bank_free;
    logic [DATA_WIDTH-1:0] sel_sample;
    logic [SEQ_W-1:0]      sel_ext;

    assign arm_rise  = arm_i & ~arm_prev_q;
    assign ramp_rise = ramp_start_i & ~ramp_prev_q;
    // The final transfer frees the read bank in the same cycle, so a frame
    // completing concurrently is committed rather than dropped.
    assign last_xfer = (r_state_q == R_DATA) && out_ready_i && out_last_q;
    assign bank_free = !rd_full_q || last_xfer;

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign busy_o       = (cap_state_q != IDLE);
    assign drop_count_o = drop_q;

    // Capture FSM: arm / ramp sequencing, settling skip, frame commit or drop
    always_comb begin
        cap_state_d = cap_state_q;
        arm_prev_d  = arm_i;
        ramp_prev_d = ramp_start_i;
        single_d    = single_q;
        skip_cnt_d  = skip_cnt_q;
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        seq_d       = seq_q;
        hdr_seq_d   = hdr_seq_q;
        drop_d      = drop_q;
        mem_we      = 1'b0;
        commit      = 1'b0;
        case (cap_state_q)
            IDLE: begin
                if (arm_rise) begin
                    single_d    = single_i;
                    cap_state_d = WAIT_RAMP;
                end
            end
            WAIT_RAMP: begin
                if (!arm_i) begin
                    cap_state_d = IDLE;
                end else if (ramp_rise) begin
                    // A strobe coincident with the edge is deliberately ignored
                    wr_addr_d  = '0;
                    skip_cnt_d = skip_i;
                    cap_state_d = (skip_i == '0) ? CAPTURE : SKIP;
                end
            end
            SKIP: begin
                if (sample_en_i) begin
                    skip_cnt_d = skip_cnt_q - SKIP_WIDTH'(1);
                    if (skip_cnt_q == SKIP_WIDTH'(1)) begin
                        cap_state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (sample_en_i) begin
                    mem_we    = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (wr_addr_q == AW'(FRAME_LEN - 1)) begin
                        if (bank_free) begin
                            commit    = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                            hdr_seq_d = seq_q;
                            seq_d     = seq_q + SEQ_W'(1);
                        end else if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                        cap_state_d = (arm_i && !single_q) ? WAIT_RAMP : IDLE;
                    end
                end
            end
            default: cap_state_d = IDLE;
        endcase
    end

    // Pick the current channel out of the prefetched row and sign-extend it
    always_comb begin
        sel_sample = rd_row_q[int'(chan_q)*DATA_WIDTH +: DATA_WIDTH];
        sel_ext    = {SEQ_W{sel_sample[DATA_WIDTH-1]}};
        sel_ext[DATA_WIDTH-1:0] = sel_sample;
    end

    // Readout FSM: header then interleaved words; the RAM output register
    // always holds the row being emitted, and the next row is fetched on the
    // same edge that consumes the row's last channel.
    always_comb begin
        r_state_d   = r_state_q;
        row_d       = row_q;
        chan_d      = chan_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        rd_full_d   = rd_full_q;
        rd_en       = 1'b0;
        rd_addr     = row_q + AW'(1);
        case (r_state_q)
            R_IDLE: begin
                if (rd_full_q) begin
                    out_data_d  = {2'b10, hdr_seq_q};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    row_d       = '0;
                    chan_d      = '0;
                    rd_en       = 1'b1;
                    rd_addr     = '0;
                    r_state_d   = R_HEADER;
                end
            end
            R_HEADER, R_DATA: begin
                if (out_ready_i) begin
                    if (r_state_q == R_DATA && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        rd_full_d   = 1'b0;
                        r_state_d   = R_IDLE;
                    end else begin
                        out_data_d = {2'b00, sel_ext};
                        out_last_d = (row_q == AW'(FRAME_LEN - 1)) &&
                                     (chan_q == CW'(N_CHAN - 1));
                        r_state_d  = R_DATA;
                        if (chan_q == CW'(N_CHAN - 1)) begin
                            chan_d = '0;
                            row_d  = row_q + AW'(1);
                            rd_en  = 1'b1;
                        end else begin
                            chan_d = chan_q + CW'(1);
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (commit) begin
            rd_full_d = 1'b1;
        end
    end

    // Frame memory: write into the capture bank, registered read of the other
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[{wr_bank_q, wr_addr_q}] <= din_i;
        end
        if (rd_en) begin
            rd_row_q <= mem[{~wr_bank_q, rd_addr}];
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cap_state_q <= IDLE;
            arm_prev_q  <= 1'b0;
            ramp_prev_q <= 1'b0;
            single_q    <= 1'b0;
            skip_cnt_q  <= '0;
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            seq_q       <= '0;
            hdr_seq_q   <= '0;
            drop_q      <= '0;
            rd_full_q   <= 1'b0;
            r_state_q   <= R_IDLE;
            row_q       <= '0;
            chan_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cap_state_q <= cap_state_d;
            arm_prev_q  <= arm_prev_d;
            ramp_prev_q <= ramp_prev_d;
            single_q    <= single_d;
            skip_cnt_q  <= skip_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            seq_q       <= seq_d;
            hdr_seq_q   <= hdr_seq_d;
            drop_q      <= drop_d;
            rd_full_q   <= rd_full_d;
            r_state_q   <= r_state_d;
            row_q       <= row_d;
            chan_q      <= chan_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmcw_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmcw_frame_ctrl
// Purpose  : Self-checking bench for fmcw_frame_ctrl (FRAME_LEN=8, N_CHAN=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmcw_frame_ctrl;

    localparam int DW = 14;
    localparam int NC = 2;
    localparam int FL = 8;
    localparam int OW = 16;
    localparam int SW = 8;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              sample_en_i;
    logic [NC*DW-1:0]  din_i;
    logic              ramp_start_i;
    logic              arm_i;
    logic              single_i;
    logic [SW-1:0]     skip_i;
    logic [OW-1:0]     out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              busy_o;
    logic [7:0]        drop_count_o;

    always #5 clk_i = ~clk_i;

    fmcw_frame_ctrl #(
        .DATA_WIDTH (DW),
        .N_CHAN     (NC),
        .FRAME_LEN  (FL),
        .OUT_WIDTH  (OW),
        .SKIP_WIDTH (SW)
    ) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .sample_en_i  (sample_en_i),
        .din_i        (din_i),
        .ramp_start_i (ramp_start_i),
        .arm_i        (arm_i),
        .single_i     (single_i),
        .skip_i       (skip_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .drop_count_o (drop_count_o)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [OW:0] got[$];      // {last, data} of each accepted word
    logic [OW:0] exp_q[$];    // expected words from the reference model
    int          cur_smp[$];  // captured sample values, s0c0, s0c1, s1c0 ...
    bit          rnd_ready = 1'b0;
    bit          stall_pend = 1'b0;
    logic [OW-1:0] stall_data;
    logic        stall_last;
    int          seq = 0;
    logic [OW-1:0] hdr_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample away from the edge, collect accepted words, check
    // that a stalled word stays put.
    task automatic cyc();
        if (rnd_ready) out_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        if (stall_pend && rst_n)
            chk("stall_hold", 32'({out_valid_o, out_last_o, out_data_o}),
                32'({1'b1, stall_last, stall_data}));
        stall_pend = rst_n && out_valid_o && !out_ready_i;
        stall_data = out_data_o;
        stall_last = out_last_o;
        if (rst_n && out_valid_o && out_ready_i) got.push_back({out_last_o, out_data_o});
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: a committed frame is a header with the sequence
    // number followed by every captured value reduced to 14 bits.
    task automatic add_frame(input int seqv);
        exp_q.push_back({1'b0, 2'b10, 14'(seqv)});
        for (int i = 0; i < cur_smp.size(); i++) begin
            int w;
            w = cur_smp[i] & 'h3FFF;
            exp_q.push_back({(i == cur_smp.size() - 1) ? 1'b1 : 1'b0, 16'(w)});
        end
    endtask

    // Ramp edge followed by nstr strobes; strobes at index >= skip are kept.
    task automatic run_frame(input int skip, input bit coinc, input bit det,
                             input bit spur, input int nstr);
        cur_smp.delete();
        skip_i = SW'(skip);
        ramp_start_i = 1'b1;
        if (coinc) begin
            sample_en_i = 1'b1;
            din_i = {14'h1555, 14'h2AAA};
        end
        cyc();
        sample_en_i = 1'b0;
        ramp_start_i = 1'b0;
        for (int n = 0; n < nstr; n++) begin
            int c0;
            int c1;
            repeat ($urandom_range(0, 2)) cyc();
            if (det) begin
                c0 = n;
                c1 = -n;
            end else begin
                c0 = int'($urandom_range(0, 16383)) - 8192;
                c1 = int'($urandom_range(0, 16383)) - 8192;
            end
            din_i = {DW'(c1), DW'(c0)};
            sample_en_i = 1'b1;
            if (spur && n == skip + 3) ramp_start_i = 1'b1;
            cyc();
            sample_en_i = 1'b0;
            ramp_start_i = 1'b0;
            if (n >= skip) begin
                cur_smp.push_back(c0);
                cur_smp.push_back(c1);
            end
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 400;
        while (got.size() < exp_q.size() && budget > 0) begin
            cyc();
            budget--;
        end
        if (budget == 0) chk({tag, "_timeout"}, 32'(got.size()), 32'(exp_q.size()));
        repeat (24) cyc();
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size())
                chk($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        sample_en_i = 1'b0;
        din_i = '0;
        ramp_start_i = 1'b0;
        arm_i = 1'b0;
        single_i = 1'b0;
        skip_i = '0;
        out_ready_i = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Reset state
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_last",  32'(out_last_o),  32'd0);
        chk("rst_data",  32'(out_data_o),  32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_drop",  32'(drop_count_o), 32'd0);

        // Continuous, skip 2, deterministic ramp data, latency check
        arm_i = 1'b1;
        cyc();
        cyc();
        chk("s1_busy", 32'(busy_o), 32'd1);
        run_frame(2, 1'b0, 1'b1, 1'b0, 2 + FL);
        chk("s1_lat_c1_valid", 32'(out_valid_o), 32'd0);
        cyc();
        chk("s1_lat_c2_valid", 32'(out_valid_o), 32'd1);
        chk("s1_lat_hdr", 32'(out_data_o), 32'h8000);
        add_frame(seq);
        seq++;
        drain("s1");

        // Random data, random ready, random skip; first frame has skip 0
        // with the ramp edge coincident with a strobe
        rnd_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            int sk;
            sk = (f == 0) ? 0 : int'($urandom_range(0, 3));
            run_frame(sk, (sk == 0), 1'b0, f[0], sk + FL);
            add_frame(seq);
            seq++;
            drain($sformatf("s2f%0d", f));
        end
        rnd_ready = 1'b0;
        out_ready_i = 1'b1;

        // Back-pressure: pending frame kept, second frame dropped
        out_ready_i = 1'b0;
        run_frame(1, 1'b0, 1'b0, 1'b0, 1 + FL);
        hdr_a = 16'h8000 | 16'(seq);
        add_frame(seq);
        seq++;
        run_frame(2, 1'b0, 1'b0, 1'b0, 2 + FL);
        cyc();
        cyc();
        chk("s3_drop", 32'(drop_count_o), 32'd1);
        chk("s3_valid_held", 32'(out_valid_o), 32'd1);
        chk("s3_hdr_held", 32'(out_data_o), 32'(hdr_a));
        out_ready_i = 1'b1;
        drain("s3a");
        run_frame(0, 1'b1, 1'b0, 1'b1, FL);
        add_frame(seq);
        seq++;
        drain("s3c");

        // Single-shot: one frame per arm rising edge
        arm_i = 1'b0;
        cyc();
        cyc();
        single_i = 1'b1;
        arm_i = 1'b1;
        cyc();
        single_i = 1'b0;
        run_frame(2, 1'b0, 1'b0, 1'b0, 2 + FL);
        add_frame(seq);
        seq++;
        cyc();
        cyc();
        chk("s4_busy_after", 32'(busy_o), 32'd0);
        run_frame(1, 1'b0, 1'b0, 1'b0, 1 + FL);
        drain("s4a");
        arm_i = 1'b0;
        cyc();
        single_i = 1'b1;
        arm_i = 1'b1;
        cyc();
        run_frame(2, 1'b0, 1'b0, 1'b0, 2 + FL);
        add_frame(seq);
        seq++;
        cyc();
        cyc();
        chk("s4b_busy_after", 32'(busy_o), 32'd0);
        drain("s4b");

        // Reset mid-capture with a pending frame
        arm_i = 1'b0;
        cyc();
        single_i = 1'b0;
        arm_i = 1'b1;
        cyc();
        out_ready_i = 1'b0;
        run_frame(2, 1'b0, 1'b0, 1'b0, 2 + FL);
        run_frame(2, 1'b0, 1'b0, 1'b0, 2 + 4);
        rst_n = 1'b0;
        stall_pend = 1'b0;
        cyc();
        cyc();
        chk("s5_rst_valid", 32'(out_valid_o), 32'd0);
        chk("s5_rst_last",  32'(out_last_o),  32'd0);
        chk("s5_rst_data",  32'(out_data_o),  32'd0);
        chk("s5_rst_busy",  32'(busy_o),      32'd0);
        chk("s5_rst_drop",  32'(drop_count_o), 32'd0);
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        arm_i = 1'b0;
        repeat (30) cyc();
        chk("s5_no_output", 32'(got.size()), 32'd0);
        got.delete();
        seq = 0;
        arm_i = 1'b1;
        cyc();
        run_frame(2, 1'b0, 1'b0, 1'b0, 2 + FL);
        add_frame(seq);
        seq++;
        drain("s5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
